// File: rtl/freq_calculator.sv
// Frequency meter: counts synchronized rising edges of an async input over a
// FREQ-cycle (1 us) gate window and reports the count as an integer MHz value.
module freq_calculator #(
  parameter int unsigned FREQ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signal,
  output logic [31:0] frequency
);

  localparam int unsigned   CW       = $clog2(FREQ);
  localparam logic [CW-1:0] CYC_LAST = CW'(FREQ - 1);

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_GATE   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          warm_q, warm_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [31:0]   edge_q, edge_d;
  logic [31:0]   freq_q, freq_d;
  logic          sync1_q, sync2_q, sync3_q;
  logic          rise_c;

  assign rise_c    = sync2_q & ~sync3_q;
  assign frequency = freq_q;

  // Next-state: warm-up primes the synchronizer, then back-to-back gate windows
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    cyc_d   = cyc_q;
    edge_d  = edge_q;
    freq_d  = freq_q;
    case (state_q)
      ST_WARMUP: begin
        warm_d = 1'b1;
        if (warm_q) begin
          state_d = ST_GATE;
          warm_d  = 1'b0;
        end
      end
      default: begin
        if (cyc_q == CYC_LAST) begin
          // A rise in the terminal cycle still belongs to this window
          freq_d = edge_q + 32'(rise_c);
          edge_d = '0;
          cyc_d  = '0;
        end else begin
          edge_d = edge_q + 32'(rise_c);
          cyc_d  = cyc_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      warm_q  <= 1'b0;
      cyc_q   <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cyc_q   <= cyc_d;
      edge_q  <= edge_d;
      freq_q  <= freq_d;
      sync1_q <= signal;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

endmodule

// File: tb/tb_freq_calculator.sv
// Scoreboard bench for freq_calculator: stimulus queues expected per-window
// results, a monitor pops and checks them at each window boundary.
module tb_freq_calculator;

  localparam int FREQ = 100;

  typedef struct {
    bit chk;
    int lo;
    int hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig = 1'b0;
  logic [31:0] frequency;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;
  int   half_cyc = 0;
  logic const_lvl = 1'b0;
  event win_done;

  freq_calculator #(.FREQ(FREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .signal    (sig),
    .frequency (frequency)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int lo, input int hi);
    total++;
    if (act >= 32'(lo) && act <= 32'(hi)) passed++;
    else $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
  endtask

  // Push n_dc unchecked (blended) windows then n checked windows, and wait them out
  task automatic expect_windows(input int n_dc, input int n, input int lo, input int hi);
    exp_t e;
    for (int i = 0; i < n_dc; i++) begin
      e = '{1'b0, 0, 0};
      sb_q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      e = '{1'b1, lo, hi};
      sb_q.push_back(e);
    end
    repeat (n_dc + n) @(win_done);
  endtask

  // Signal generator: toggles every half_cyc clocks, 3 ns after the clock edge
  initial begin : gen
    int ph = 0;
    forever begin
      @(posedge clk);
      #3;
      if (half_cyc == 0) sig = const_lvl;
      else begin
        ph++;
        if (ph >= half_cyc) begin
          ph  = 0;
          sig = ~sig;
        end
      end
    end
  end

  // Monitor: window boundaries are at edge 2+FREQ after release, then every FREQ
  initial begin : monitor
    int   since = 0;
    exp_t prev;
    exp_t cur;
    prev = '{1'b1, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        since = 0;
        prev  = '{1'b1, 0, 0};
      end else begin
        since++;
        if (since >= 2 + FREQ && (since - 2) % FREQ == 0) begin
          if (sb_q.size() == 0) begin
            total++;
            $display("FAIL scoreboard_empty: got value %0d with no expectation at %0t", frequency, $time);
          end else begin
            cur = sb_q.pop_front();
            if (cur.chk) check("window_result", frequency, cur.lo, cur.hi);
            prev = cur;
          end
          -> win_done;
        end else if (since >= 1 + FREQ && (since - 1) % FREQ == 0) begin
          if (prev.chk) check("hold_before_update", frequency, prev.lo, prev.hi);
        end
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d/%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst       = 1'b1;
    half_cyc  = 1;
    const_lvl = 1'b0;
    #1;
    check("reset_frequency", frequency, 0, 0);
    #9;
    rst = 1'b0;
    expect_windows(0, 3, 50, 50);

    half_cyc = 5;
    expect_windows(1, 2, 10, 10);

    half_cyc  = 0;
    const_lvl = 1'b0;
    expect_windows(1, 2, 0, 0);

    const_lvl = 1'b1;
    expect_windows(1, 2, 0, 0);

    half_cyc = 4;
    expect_windows(1, 4, 12, 13);

    half_cyc = 1;
    expect_windows(1, 2, 50, 50);

    repeat (37) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clears", frequency, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expect_windows(0, 2, 50, 50);

    half_cyc = 2;
    expect_windows(1, 3, 25, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
